// File: rtl/add_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package add_pkg;

  // Datapath word width.
  localparam int WORD_W = 32;

  // Sequencer states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Signed overflow of a two's-complement add, using the word's sign bits.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/mp_add_seq_g_rca32.sv
// Gate-level 32-bit ripple-carry adder; purely combinational.
module g_rca32
  import add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  logic [WORD_W:0] c;
  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] g;

  assign c[0] = cin;

  // One full adder per bit, carry rippling from bit 0 upward.
  for (genvar i = 0; i < WORD_W; i++) begin : g_fa
    assign p[i]   = a[i] ^ b[i];
    assign g[i]   = a[i] & b[i];
    assign sum[i] = p[i] ^ c[i];
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign cout = c[WORD_W];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: streams word pairs LS-word first
// through one 32-bit adder, chaining the carry through a register.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first (least significant) word of an operand;
//       | mode and carry-in come from in_sub
// RUN   | inside a multi-word operand; mode from sub_q, carry from carry_q
module mp_add_seq
  import add_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int IDXW      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_a,
  input  logic [WORD_W-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic              out_err
);

  localparam logic [0:0]      IDLE    = 1'(ST_IDLE);
  localparam logic [0:0]      RUN     = 1'(ST_RUN);
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(MAX_WORDS - 1);

  logic [0:0]        state;
  logic              carry_q;
  logic              sub_q;
  logic [IDXW-1:0]   idx;

  logic              accept;
  logic              mode;
  logic              cin;
  logic [WORD_W-1:0] b_eff;
  logic [WORD_W-1:0] sum;
  logic              cout;
  logic              at_max;
  logic              final_word;
  logic              err_word;
  logic              ovf;

  // A single output register: accept whenever it is empty or draining now.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Mode and carry-in come from the input on the first word, else from the
  // registers latched on that first word.
  always_comb begin
    mode = sub_q;
    cin  = carry_q;
    if (state == IDLE) begin
      mode = in_sub;
      cin  = in_sub;
    end
  end

  assign b_eff = in_b ^ {WORD_W{mode}};

  g_rca32 u_rca (
    .a    (in_a),
    .b    (b_eff),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  // idx is 0 in IDLE, so the limit test also covers MAX_WORDS == 1.
  assign at_max     = (idx == IDX_MAX);
  assign final_word = in_last || at_max;
  assign err_word   = !in_last && at_max;
  assign ovf        = signed_ovf(in_a[WORD_W-1], b_eff[WORD_W-1], sum[WORD_W-1]);

  // Sequencer state, carry chain and word index advance only on an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      if (final_word) begin
        state   <= IDLE;
        carry_q <= 1'b0;
        sub_q   <= 1'b0;
        idx     <= '0;
      end else begin
        state   <= RUN;
        carry_q <= cout;
        sub_q   <= mode;
        idx     <= idx + 1'b1;
      end
    end
  end

  // Output register: loads on accept, holds while stalled, empties on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_idx   <= idx;
      out_last  <= final_word;
      out_cout  <= final_word & cout;
      out_ovf   <= final_word & ovf;
      out_err   <= err_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mp_add_seq.md
Name: mp_add_seq

Overview:
Multi-precision add/subtract sequencer built around the 32-bit ripple-carry adder.
- Accepts operands as a stream of 32-bit word pairs, least-significant word first.
- Feeds each pair to the adder and chains the carry between words through a register.
- Emits one registered sum word per input word, plus the final carry and the signed-overflow flag.
- Sits between the operand-fetch logic and any consumer that needs arbitrary-length (up to MAX_WORDS × 32-bit) addition.

Parameters:
MAX_WORDS, 8, maximum words per operand; a longer operand is force-terminated with an error.
IDXW, $clog2(MAX_WORDS) (minimum 1), width of the word-index counter.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  input word pair valid.
in_ready  output  1  block can accept a word this cycle.
in_a  input  32  operand A word.
in_b  input  32  operand B word.
in_sub  input  1  subtract mode; sampled only on the first word of an operand.
in_last  input  1  marks the most-significant word of the operand.
out_valid  output  1  result word valid.
out_ready  input  1  consumer accepts the result word.
out_sum  output  32  result word.
out_idx  output  IDXW  word index of out_sum; 0 = least significant.
out_last  output  1  final word of the result.
out_cout  output  1  carry out of the final word; 0 when out_last=0.
out_ovf  output  1  signed overflow of the full-width result; 0 when out_last=0.
out_err  output  1  operand exceeded MAX_WORDS without in_last; valid with out_last.

Behaviour:
- Reset (async assert): state=IDLE, carry_q=0, sub_q=0, idx=0, all out_* = 0. Deassertion is synchronous to clk (2-flop release in the wrapper).
- Handshakes:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (single output register; full throughput).
  - out_* stay stable while out_valid && !out_ready.
- Datapath, per accepted word:
  - b_eff = in_b ^ {32{mode}}.
  - cin = mode in IDLE, carry_q in RUN.
  - mode = in_sub in IDLE, sub_q in RUN.
  - Sum = adder(in_a, b_eff, cin). Registered into out_sum on the next clk edge (latency 1 cycle).
- State machine (IDLE / RUN):
  - IDLE + accept, in_last=1: emit idx 0 with out_last=1; stay IDLE.
  - IDLE + accept, in_last=0: latch sub_q=in_sub and carry_q=cout; idx←1; go RUN.
  - RUN + accept, in_last=0 and idx<MAX_WORDS-1: carry_q=cout; idx++.
  - RUN + accept, in_last=1: emit out_last=1; go IDLE; idx←0.
  - RUN + accept, in_last=0 and idx==MAX_WORDS-1: emit out_last=1, out_err=1; go IDLE. The next accepted word starts a new operand.
- Final word:
  - out_cout = adder cout.
  - out_ovf = (in_a[31] == b_eff[31]) && (sum[31] != in_a[31]).
  - Subtract: out_cout=1 means no borrow.
- No state changes without an input transfer.
- Simultaneous output drain and input accept in the same cycle is legal and loses no word.
- Reset mid-operand discards the partial result; out_valid drops immediately.

Decomposition:
- Shared package add_pkg: WORD_W=32, state enum {IDLE, RUN}.
- One sub-module: the existing gate-level 32-bit ripple-carry adder g_rca32, instantiated once, combinational.
- All registers and the FSM live in mp_add_seq.

Test Plan:
- Single word, A=0xFFFFFFFF, B=0x00000001, sub=0, last=1 → out_sum=0x00000000, out_idx=0, out_last=1, out_cout=1, out_ovf=0; out_valid exactly 1 cycle after accept.
- Two-word add, A={0x00000001,0xFFFFFFFF}, B={0x00000000,0x00000001} → word0 sum 0x00000000; word1 sum 0x00000002, out_cout=0, out_ovf=0.
- Two-word subtract (sub=1 on word0 only), A=0x00000001_00000000, B=0x00000000_00000001 → 0xFFFFFFFF, then 0x00000000 with out_cout=1. Repeat with in_sub toggled on word1: same result.
- Single-word 0x7FFFFFFF+0x00000001 → sum 0x80000000, out_ovf=1, out_cout=0.
- Stream of 3 words with out_ready held low 4 cycles after the first result → in_ready=0 and out_* frozen while stalled; all 3 words delivered in order with idx 0,1,2.
- Error and reset:
  - MAX_WORDS=4, 5 words with no in_last → 4th output has out_last=1, out_err=1; 5th word restarts at idx 0 with cin=in_sub.
  - Assert rst during word 1 of 3 → out_valid=0 immediately; the next operand starts from IDLE.
